chrono_controller: RTL and testbench
====================================

# chrono_controller

Sequencing controller for the VGA chronometer. It owns the stopwatch time base and the start/stop/lap/clear state machine, and drives the `second`, `minute` and `hour` inputs of the RGB character renderer. Display values change only at frame boundaries, so the renderer never shows a torn frame. It sits between the board push-buttons, the VGA sync generator (frame pulse) and the RGB renderer.

## Interface
- `TICK_DIV`, 25_000_000: clk cycles per counted second (25 MHz pixel clock).
- `HOUR_MOD`, 24: hour wrap modulus; legal range 1..100.
- `clk` input 1: pixel clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_start_stop` input 1: level, debounced upstream, asynchronous to clk.
- `btn_lap` input 1: level, debounced upstream, asynchronous to clk.
- `btn_clear` input 1: level, debounced upstream, asynchronous to clk.
- `frame_end` input 1: one-cycle pulse from the sync generator at start of vertical blanking.
- `second` output 6: displayed seconds, 0..59.
- `minute` output 6: displayed minutes, 0..59.
- `hour` output 8: displayed hours, 0..HOUR_MOD-1.
- `running` output 1: high in RUN and LAP.
- `lap_active` output 1: high in LAP.
- `tick` output 1: one-cycle pulse per counted second.

## Operation
- Each button passes through a 2-FF synchronizer and a rising-edge detector, giving one event per press. Holding a button produces no repeats.
- Event priority in the same cycle is clear > start_stop > lap. Lower-priority events in that cycle are dropped.
- FSM states: IDLE, RUN, PAUSED, LAP.
  - IDLE: start_stop -> RUN. Lap and clear are ignored.
  - RUN: start_stop -> PAUSED. Lap -> LAP and snapshots the live counters into the lap registers. Clear is ignored.
  - LAP: lap -> RUN. Start_stop -> PAUSED, which releases the freeze. Clear is ignored.
  - PAUSED: start_stop -> RUN. Clear -> IDLE, zeroing the live counters, prescaler and lap registers.
- The prescaler counts 0..TICK_DIV-1 only in RUN and LAP. It holds its value otherwise, so sub-second phase is preserved across pause/resume.
- On the prescaler wrap, seconds increment with carries:
  - seconds 59 -> 0, minute +1;
  - minutes 59 -> 0, hour +1;
  - hour HOUR_MOD-1 -> 0.
  - Full wrap (HOUR_MOD-1:59:59 -> 0:00:00) has no overflow flag.
- Display source is the lap registers in LAP and the live counters otherwise. Display registers load from the source only on a cycle where `frame_end` is high.

## Timing
- Reset values: all outputs 0, state IDLE, prescaler 0, live and lap counters 0.
- Button latency: with the input high before rising edge k, the state change is visible after edge k+2.
- Tick timing:
  - Counters increment at the edge where the prescaler is at TICK_DIV-1.
  - `tick` is high for the cycle after that edge.
- Display latency: outputs update at the edge sampling `frame_end` high. They show the live/lap register value from before that edge.
- Simultaneous events:
  - Increment and `frame_end` in the same cycle: the display takes the pre-increment value.
  - Lap event and `frame_end` in the same cycle: the display takes the live value; the freeze applies from the next frame.
- After clear, the display reads 0:00:00 from the next `frame_end`. The display holds its old value until then.
- Reset asserted mid-count: all registers clear immediately (asynchronously). The first button event is accepted 2 edges after `reset_n` deasserts.

## Structure
- `chrono_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, PAUSED=2, LAP=3);
  - SEC_MAX=59 and MIN_MAX=59;
  - output field widths (6/6/8), shared with the RGB renderer.
- One sub-module, `btn_sync_edge` (2-FF sync + edge detect, async active-low reset), instantiated three times.
- The prescaler, time counters, FSM and display registers live in the top module.

## Test plan
Simulation uses TICK_DIV=4 and HOUR_MOD=24, with `frame_end` pulsed every 10 cycles.
- Reset, then press start_stop: `running`=1 after 2 edges; `tick` every 4 cycles; display reaches 0:00:05 by the first `frame_end` after the 5th tick.
- Preload live counters to 23:59:59 and run one tick -> display 0:00:00 at the next `frame_end`; no X on any output.
- In RUN at 0:00:07, press lap: display stays 0:00:07 while the live count advances. Press lap again: display shows the live value at the next `frame_end`.
- In RUN, press clear: ignored. Stop, then clear: display 0:00:00 at the next `frame_end`, state IDLE, prescaler 0.
- Assert start_stop and clear in the same cycle while PAUSED: clear wins, state IDLE. Hold start_stop for 50 cycles: exactly one event.
- Pause at prescaler=2, wait 100 cycles, resume: next `tick` arrives 2 cycles after the resume edge.

Source files
------------

// File: rtl/chrono_pkg.sv
// chrono_pkg
// Shared definitions for the VGA chronometer: controller state encoding,
// time-field limits and the display field widths that the RGB character
// renderer also uses for its second/minute/hour inputs.
package chrono_pkg;

   // Controller states; the encoding is shared with debug tooling.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      LAP    = 2'd3
   } chrono_state_t;

   // Display field widths, shared with the RGB renderer.
   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 8;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   // The time base advances only in these states.
   function automatic logic is_counting(input chrono_state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge
// Brings one asynchronous, already-debounced push-button level into the clk
// domain through a two-flop synchronizer and turns each rising edge into a
// single-cycle event. Holding the button produces no further events.
//
// Ports:
//   clk     - pixel clock
//   reset_n - asynchronous active-low reset
//   btn     - raw button level, asynchronous to clk
//   pulse   - one-cycle event per press, in the clk domain
module btn_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic pulse
);

   logic sync_q1;
   logic sync_q2;
   logic prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
      end
   end

   assign pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/chrono_controller.sv
// chrono_controller
// Sequencing controller for the VGA chronometer. Owns the stopwatch time base
// (prescaler plus seconds/minutes/hours), the start/stop/lap/clear state
// machine and the display registers feeding the RGB renderer. The display
// only reloads on frame_end so the renderer never shows a torn frame.
//
// Ports:
//   clk, reset_n    - pixel clock, asynchronous active-low reset
//   btn_start_stop  - start/stop button level (asynchronous)
//   btn_lap         - lap button level (asynchronous)
//   btn_clear       - clear button level (asynchronous)
//   frame_end       - one-cycle pulse at start of vertical blanking
//   second/minute/hour - displayed time
//   running         - high in RUN and LAP
//   lap_active      - high in LAP
//   tick            - one-cycle pulse per counted second
module chrono_controller
   import chrono_pkg::*;
#(
   parameter int TICK_DIV = 25_000_000,
   parameter int HOUR_MOD = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              btn_start_stop,
   input  logic              btn_lap,
   input  logic              btn_clear,
   input  logic              frame_end,
   output logic [SEC_W-1:0]  second,
   output logic [MIN_W-1:0]  minute,
   output logic [HOUR_W-1:0] hour,
   output logic              running,
   output logic              lap_active,
   output logic              tick
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [HOUR_W-1:0]  HOUR_MAX  = HOUR_W'(HOUR_MOD - 1);

   chrono_state_t       state;
   logic [PRESC_W-1:0]  presc;
   logic [SEC_W-1:0]    live_sec;
   logic [MIN_W-1:0]    live_min;
   logic [HOUR_W-1:0]   live_hour;
   logic [SEC_W-1:0]    lap_sec;
   logic [MIN_W-1:0]    lap_min;
   logic [HOUR_W-1:0]   lap_hour;

   logic ss_ev;
   logic lap_ev;
   logic clear_ev;
   logic ss_req;
   logic lap_req;
   logic do_clear;
   logic do_snap;
   logic counting;

   btn_sync_edge u_sync_ss (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_start_stop),
      .pulse   (ss_ev)
   );

   btn_sync_edge u_sync_lap (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_lap),
      .pulse   (lap_ev)
   );

   btn_sync_edge u_sync_clear (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_clear),
      .pulse   (clear_ev)
   );

   // Clear outranks start/stop, which outranks lap; a losing event is dropped
   // even when the winner turns out to be ignored in the current state.
   assign ss_req   = ss_ev & ~clear_ev;
   assign lap_req  = lap_ev & ~clear_ev & ~ss_ev;
   assign do_clear = clear_ev & (state == PAUSED);
   assign do_snap  = lap_req & (state == RUN);
   assign counting = is_counting(state);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         running    <= 1'b0;
         lap_active <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ss_req) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (ss_req) begin
                  state   <= PAUSED;
                  running <= 1'b0;
               end else if (lap_req) begin
                  state      <= LAP;
                  lap_active <= 1'b1;
               end
            end
            LAP: begin
               if (ss_req) begin
                  state      <= PAUSED;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end else if (lap_req) begin
                  state      <= RUN;
                  lap_active <= 1'b0;
               end
            end
            PAUSED: begin
               if (clear_ev) begin
                  state <= IDLE;
               end else if (ss_req) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               running    <= 1'b0;
               lap_active <= 1'b0;
            end
         endcase
      end
   end

   // The prescaler holds outside RUN/LAP so the sub-second phase survives a
   // pause. The lap snapshot takes the live value from before this edge's
   // increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc     <= '0;
         live_sec  <= '0;
         live_min  <= '0;
         live_hour <= '0;
         lap_sec   <= '0;
         lap_min   <= '0;
         lap_hour  <= '0;
         tick      <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (do_clear) begin
            presc     <= '0;
            live_sec  <= '0;
            live_min  <= '0;
            live_hour <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_hour  <= '0;
         end else begin
            if (do_snap) begin
               lap_sec  <= live_sec;
               lap_min  <= live_min;
               lap_hour <= live_hour;
            end
            if (counting) begin
               if (presc == PRESC_MAX) begin
                  presc <= '0;
                  tick  <= 1'b1;
                  if (live_sec == SEC_MAX) begin
                     live_sec <= '0;
                     if (live_min == MIN_MAX) begin
                        live_min <= '0;
                        if (live_hour == HOUR_MAX) begin
                           live_hour <= '0;
                        end else begin
                           live_hour <= live_hour + 1'b1;
                        end
                     end else begin
                        live_min <= live_min + 1'b1;
                     end
                  end else begin
                     live_sec <= live_sec + 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
         end
      end
   end

   // Display reload uses the registered values from before this edge, so a
   // same-cycle increment or lap event only shows up at the following frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         second <= '0;
         minute <= '0;
         hour   <= '0;
      end else if (frame_end) begin
         if (state == LAP) begin
            second <= lap_sec;
            minute <= lap_min;
            hour   <= lap_hour;
         end else begin
            second <= live_sec;
            minute <= live_min;
            hour   <= live_hour;
         end
      end
   end

endmodule

// File: tb/tb_chrono_controller.sv
// tb_chrono_controller
// Self-checking bench for chrono_controller. A behavioural model tracks the
// stopwatch as a total count of elapsed seconds and checks every output each
// cycle; directed literal checks pin key moments of the scenario. A second
// instance with a tiny time base exercises the hour carry and the full wrap.
module tb_chrono_controller;

   localparam int TD = 4;
   localparam int HM = 24;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;
   localparam int M_LAP    = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       btn_ss = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic       frame_end = 1'b0;
   logic       btn_w = 1'b0;
   logic       w_zero = 1'b0;

   logic [5:0] second, minute;
   logic [7:0] hour;
   logic       running, lap_active, tick;
   logic [5:0] w_second, w_minute;
   logic [7:0] w_hour;
   logic       w_running, w_lap_active, w_tick;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int fcnt = 0;
   int k;
   int s;
   int p;
   int r;

   // Model state: elapsed time as total seconds, not as carried fields.
   int         m_mode = M_IDLE;
   int         m_elapsed = 0;
   int         m_phase = 0;
   int         m_lap = 0;
   int         m_disp = 0;
   int         m_tick = 0;
   int         live_before;
   bit         ev_c, ev_s, ev_l;
   logic [2:0] h_ss = 3'b000;
   logic [2:0] h_lap = 3'b000;
   logic [2:0] h_clr = 3'b000;

   chrono_controller #(.TICK_DIV(TD), .HOUR_MOD(HM)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .btn_start_stop (btn_ss),
      .btn_lap        (btn_lap),
      .btn_clear      (btn_clr),
      .frame_end      (frame_end),
      .second         (second),
      .minute         (minute),
      .hour           (hour),
      .running        (running),
      .lap_active     (lap_active),
      .tick           (tick)
   );

   chrono_controller #(.TICK_DIV(2), .HOUR_MOD(2)) dut_w (
      .clk            (clk),
      .reset_n        (reset_n),
      .btn_start_stop (btn_w),
      .btn_lap        (w_zero),
      .btn_clear      (w_zero),
      .frame_end      (frame_end),
      .second         (w_second),
      .minute         (w_minute),
      .hour           (w_hour),
      .running        (w_running),
      .lap_active     (w_lap_active),
      .tick           (w_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, actual, expected);
      end
   endtask

   // Returns just after the negedge that precedes clock edge e.
   task automatic to_edge(input int e);
      if (edge_cnt > e - 1) begin
         checks++;
         errors++;
         $display("[TB] FAIL schedule: edge %0d already passed, now at %0d", e, edge_cnt);
      end else begin
         while (edge_cnt != e - 1) @(negedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input int e, input logic ss, input logic lp, input logic clr);
      to_edge(e);
      btn_ss  = ss;
      btn_lap = lp;
      btn_clr = clr;
   endtask

   // Free-running frame pulse, one cycle in every ten.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         frame_end = (fcnt == 9);
         fcnt = (fcnt + 1) % 10;
      end
   end

   // Behavioural model, advanced at every clock edge or reset assertion.
   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_mode = M_IDLE;
            m_elapsed = 0;
            m_phase = 0;
            m_lap = 0;
            m_disp = 0;
            m_tick = 0;
            h_ss = 3'b000;
            h_lap = 3'b000;
            h_clr = 3'b000;
         end else begin
            // A press sampled two edges ago (and not three) acts on this edge.
            ev_c = h_clr[1] && !h_clr[2];
            ev_s = h_ss[1] && !h_ss[2];
            ev_l = h_lap[1] && !h_lap[2];
            h_clr = {h_clr[1:0], btn_clr};
            h_ss  = {h_ss[1:0], btn_ss};
            h_lap = {h_lap[1:0], btn_lap};
            live_before = m_elapsed;
            if (frame_end) m_disp = (m_mode == M_LAP) ? m_lap : m_elapsed;
            m_tick = 0;
            if (m_mode == M_RUN || m_mode == M_LAP) begin
               m_phase++;
               if (m_phase == TD) begin
                  m_phase = 0;
                  m_elapsed = (m_elapsed + 1) % (HM * 3600);
                  m_tick = 1;
               end
            end
            if (ev_c) begin
               if (m_mode == M_PAUSED) begin
                  m_mode = M_IDLE;
                  m_elapsed = 0;
                  m_phase = 0;
                  m_lap = 0;
               end
            end else if (ev_s) begin
               m_mode = (m_mode == M_IDLE || m_mode == M_PAUSED) ? M_RUN : M_PAUSED;
            end else if (ev_l) begin
               if (m_mode == M_RUN) begin
                  m_mode = M_LAP;
                  m_lap = live_before;
               end else if (m_mode == M_LAP) begin
                  m_mode = M_RUN;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check_output("model_second", int'(second), m_disp % 60);
         check_output("model_minute", int'(minute), (m_disp / 60) % 60);
         check_output("model_hour", int'(hour), m_disp / 3600);
         check_output("model_running", int'(running), (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
         check_output("model_lap_active", int'(lap_active), (m_mode == M_LAP) ? 1 : 0);
         check_output("model_tick", int'(tick), m_tick);
         check_output("no_x", int'($isunknown({second, minute, hour, running, lap_active, tick,
                                               w_second, w_minute, w_hour, w_running,
                                               w_lap_active, w_tick})), 0);
      end
   end

   initial begin
      #1 reset_n = 1'b0;
      @(negedge clk);
      #1;
      check_output("reset_second", int'(second), 0);
      check_output("reset_minute", int'(minute), 0);
      check_output("reset_hour", int'(hour), 0);
      check_output("reset_running", int'(running), 0);
      check_output("reset_lap_active", int'(lap_active), 0);
      check_output("reset_tick", int'(tick), 0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      k = edge_cnt + 4;

      // Start: running rises after the second edge following the press.
      apply_stimulus(k, 1, 0, 0);
      apply_stimulus(k + 2, 0, 0, 0);
      check_output("start_running_early", int'(running), 0);
      to_edge(k + 3);
      check_output("start_running", int'(running), 1);

      // Lap at 0:00:07, display frozen while live count advances.
      apply_stimulus(k + 30, 0, 1, 0);
      apply_stimulus(k + 32, 0, 0, 0);
      to_edge(k + 50);
      check_output("lap_frozen_second", int'(second), 7);
      check_output("lap_active_on", int'(lap_active), 1);
      btn_lap = 1'b1;
      apply_stimulus(k + 52, 0, 0, 0);

      // Pause: live count is 15 with the prescaler wrapped to 0.
      apply_stimulus(k + 60, 1, 0, 0);
      apply_stimulus(k + 62, 0, 0, 0);
      to_edge(k + 80);
      check_output("paused_second", int'(second), 15);
      check_output("paused_running", int'(running), 0);

      // Resume, then clear while running is ignored.
      btn_ss = 1'b1;
      apply_stimulus(k + 82, 0, 0, 0);
      apply_stimulus(k + 84, 0, 0, 1);
      apply_stimulus(k + 86, 0, 0, 0);
      to_edge(k + 88);
      check_output("clear_in_run_ignored", int'(running), 1);

      // Pause with the prescaler at 2, wait, resume: tick 2 edges later.
      apply_stimulus(k + 90, 1, 0, 0);
      apply_stimulus(k + 92, 0, 0, 0);
      apply_stimulus(k + 200, 1, 0, 0);
      apply_stimulus(k + 202, 0, 0, 0);
      to_edge(k + 203);
      check_output("resume_tick_edge1", int'(tick), 0);
      to_edge(k + 204);
      check_output("resume_tick_edge2", int'(tick), 0);
      to_edge(k + 205);
      check_output("resume_tick_arrives", int'(tick), 1);
      check_output("resume_tick_second", int'(second) <= 18 ? 1 : 0, 1);

      // Stop at 19 seconds, then clear.
      apply_stimulus(k + 206, 1, 0, 0);
      apply_stimulus(k + 208, 0, 0, 0);
      apply_stimulus(k + 210, 0, 0, 1);
      apply_stimulus(k + 212, 0, 0, 0);
      to_edge(k + 225);
      check_output("cleared_second", int'(second), 0);
      check_output("cleared_running", int'(running), 0);

      // Run two seconds, pause, then start_stop and clear together.
      apply_stimulus(k + 230, 1, 0, 0);
      apply_stimulus(k + 232, 0, 0, 0);
      apply_stimulus(k + 240, 1, 0, 0);
      apply_stimulus(k + 242, 0, 0, 0);
      apply_stimulus(k + 250, 1, 0, 1);
      apply_stimulus(k + 252, 1, 0, 0);
      apply_stimulus(k + 300, 0, 0, 0);
      to_edge(k + 310);
      check_output("clear_wins_running", int'(running), 0);
      check_output("clear_wins_second", int'(second), 0);

      // Lap in IDLE is ignored.
      apply_stimulus(k + 312, 0, 1, 0);
      apply_stimulus(k + 314, 0, 0, 0);
      to_edge(k + 318);
      check_output("lap_in_idle_ignored", int'(lap_active), 0);

      // Holding start_stop for 50 cycles gives exactly one event.
      apply_stimulus(k + 320, 1, 0, 0);
      apply_stimulus(k + 370, 0, 0, 0);
      to_edge(k + 380);
      check_output("held_button_single_event", int'(running), 1);

      // Small instance: 7199 ticks reach 1:59:59, one more wraps to 0:00:00.
      s = k + 400;
      to_edge(s);
      btn_w = 1'b1;
      to_edge(s + 3);
      btn_w = 1'b0;
      p = s + 2 * 7199;
      to_edge(p);
      btn_w = 1'b1;
      to_edge(p + 3);
      btn_w = 1'b0;
      to_edge(p + 25);
      check_output("wrap_pre_hour", int'(w_hour), 1);
      check_output("wrap_pre_minute", int'(w_minute), 59);
      check_output("wrap_pre_second", int'(w_second), 59);
      check_output("wrap_pre_running", int'(w_running), 0);
      r = p + 26;
      to_edge(r);
      btn_w = 1'b1;
      to_edge(r + 1);
      btn_w = 1'b0;
      to_edge(r + 2);
      btn_w = 1'b1;
      to_edge(r + 4);
      btn_w = 1'b0;
      to_edge(r + 25);
      check_output("wrap_hour", int'(w_hour), 0);
      check_output("wrap_minute", int'(w_minute), 0);
      check_output("wrap_second", int'(w_second), 0);
      check_output("wrap_running", int'(w_running), 0);

      // Reset mid-count clears everything without waiting for a clock edge.
      to_edge(r + 30);
      check_output("precount_running", int'(running), 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("async_reset_running", int'(running), 0);
      check_output("async_reset_time", int'({second, minute, hour}), 0);
      check_output("async_reset_tick", int'(tick), 0);
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
